// File: rtl/pktbuf_rd_arb.sv
// pktbuf_rd_arb: two-port packet-buffer read arbiter with burst locking and in-order tag return
package pktbuf_pkg;
    localparam int PKTBUF_AWIDTH = 12;
    typedef logic [31:0] flit_t;
endpackage

module pktbuf_rd_arb
    import pktbuf_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               rd_req,
    input  logic [PKTBUF_AWIDTH-1:0] rd_addr0,
    input  logic [PKTBUF_AWIDTH-1:0] rd_addr1,
    input  logic [1:0]               rd_last,
    output logic [1:0]               rd_gnt,
    output logic [1:0]               rd_valid,
    output flit_t                    rd_data,
    output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_readaddress,
    output logic                     pkt_buffer_read,
    input  logic                     pkt_buffer_readvalid,
    input  flit_t                    pkt_buffer_readdata,
    output logic [31:0]              stats_rd0,
    output logic [31:0]              stats_rd1,
    output logic                     err_unexpected
);
    localparam int TW = $clog2(MAX_OUTSTANDING);
    logic [TW:0]   count;
    logic [TW-1:0] wr_ptr, rd_ptr;
    logic          tags [MAX_OUTSTANDING];
    logic          owner, locked, last_winner;
    logic          stall, win, ok, pop;
    always_comb begin
        stall = count == (TW+1)'(MAX_OUTSTANDING);
        win = locked ? owner : (&rd_req ? ~last_winner : rd_req[1]);
        ok = (locked ? rd_req[owner] : |rd_req) & ~stall;
        rd_gnt = {win & ok, ~win & ok};
        pop = pkt_buffer_readvalid & (count != '0);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            owner <= 1'b0;
            locked <= 1'b0;
            last_winner <= 1'b1;
            pkt_buffer_read <= 1'b0;
            pkt_buffer_readaddress <= '0;
            rd_valid <= 2'b00;
            rd_data <= '0;
            stats_rd0 <= '0;
            stats_rd1 <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (ok) begin
                tags[wr_ptr] <= win;
                wr_ptr <= wr_ptr + TW'(1);
                last_winner <= win;
                owner <= win;
                locked <= ~rd_last[win];
                pkt_buffer_readaddress <= win ? rd_addr1 : rd_addr0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + TW'(1);
                rd_data <= pkt_buffer_readdata;
            end
            count <= count + (TW+1)'(ok) - (TW+1)'(pop);
            pkt_buffer_read <= ok;
            rd_valid <= pop ? (tags[rd_ptr] ? 2'b10 : 2'b01) : 2'b00;
            stats_rd0 <= stats_rd0 + 32'(pop & ~tags[rd_ptr]);
            stats_rd1 <= stats_rd1 + 32'(pop & tags[rd_ptr]);
            err_unexpected <= err_unexpected | (pkt_buffer_readvalid & ~pop);
        end
    end
endmodule
